serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/half_adder.sv | 12 +
 rtl/serial_adder_ctrl.sv | 88 ++++++++
 tb/tb_serial_adder_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder; two of these plus an OR form the serial full-adder slice.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial a+b, LSB first, one bit per clock through a single full-adder slice.
// Results land in sum/carry only at the end of the last RUN cycle and hold until the next completion.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh_a, sh_b, acc;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             s0, c0, c1, fa_s, fa_c;

    half_adder u_ha0 (.a(sh_a[0]), .b(sh_b[0]), .s(s0),   .c(c0));
    half_adder u_ha1 (.a(s0),      .b(cy),      .s(fa_s), .c(c1));
    assign fa_c = c0 | c1;

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            cy    <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a <= a;
                        sh_b <= b;
                        acc  <= '0;
                        cy   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    // sum bits enter at the MSB so bit 0 reaches position 0 after WIDTH shifts
                    acc  <= {fa_s, acc[WIDTH-1:1]};
                    cy   <= fa_c;
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        sum   <= {fa_s, acc[WIDTH-1:1]};
                        carry <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8: vector table, corner sequences, random back-to-back pairs.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b, sum;
    logic         busy, done, carry;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [W-1:0] last_sum;
    logic         last_carry;
    int           done_cyc;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t tbl[7];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .carry(carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Start in the current cycle, then check busy/done/hold for cycles T+1..T+9.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] es, input logic ec);
        @(negedge clk);
        start = 1'b1; a = va; b = vb;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            chk("busy", int'(busy), int'(k <= W));
            chk("done", int'(done), int'(k == W + 1));
            if (k <= W) begin
                chk("sum_hold_run", int'(sum), int'(last_sum));
                chk("carry_hold_run", int'(carry), int'(last_carry));
            end else begin
                chk("sum", int'(sum), int'(es));
                chk("carry", int'(carry), int'(ec));
                done_cyc = cyc;
            end
        end
        last_sum   = es;
        last_carry = ec;
    endtask

    initial begin
        int ndone, prev_done, full;
        logic [W-1:0] ra, rb;

        tbl[0] = '{a: 8'd3,   b: 8'd5,   s: 8'd8,   c: 1'b0};
        tbl[1] = '{a: 8'd255, b: 8'd1,   s: 8'd0,   c: 1'b1};
        tbl[2] = '{a: 8'd200, b: 8'd100, s: 8'd44,  c: 1'b1};
        tbl[3] = '{a: 8'd170, b: 8'd85,  s: 8'd255, c: 1'b0};
        tbl[4] = '{a: 8'd128, b: 8'd128, s: 8'd0,   c: 1'b1};
        tbl[5] = '{a: 8'd255, b: 8'd255, s: 8'd254, c: 1'b1};
        tbl[6] = '{a: 8'd0,   b: 8'd0,   s: 8'd0,   c: 1'b0};

        rst = 1'b1; start = 1'b1; a = 8'hff; b = 8'hff;
        last_sum = '0; last_carry = 1'b0; done_cyc = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_carry", int'(carry), 0);
        rst = 1'b0; start = 1'b0;

        for (int i = 0; i < 7; i++) run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c);

        // Zero result then 20 idle cycles of stable outputs
        run_op(8'd77, 8'd11, 8'd88, 1'b0);
        run_op(8'd0, 8'd0, 8'd0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("hold_sum", int'(sum), 0);
            chk("hold_carry", int'(carry), 0);
            chk("hold_done", int'(done), 0);
            chk("hold_busy", int'(busy), 0);
        end

        // Start re-pulsed mid-RUN with different operands must be ignored
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd27;
        ndone = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            start = (k == 3 || k == 9);
            a = 8'd1; b = 8'd1;
            if (done) begin
                ndone++;
                chk("ign_done_time", k, W + 1);
                chk("ign_sum", int'(sum), 127);
                chk("ign_carry", int'(carry), 0);
            end
        end
        start = 1'b0;
        chk("ign_done_count", ndone, 1);
        last_sum = 8'd127; last_carry = 1'b0;

        // Reset in cycle T+4 aborts without a done pulse
        @(negedge clk);
        start = 1'b1; a = 8'd50; b = 8'd60;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_sum", int'(sum), 0);
        chk("abort_carry", int'(carry), 0);
        rst = 1'b0; start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        last_sum = '0; last_carry = 1'b0;
        run_op(8'd15, 8'd15, 8'd30, 1'b0);

        // Back-to-back: each start lands in the IDLE cycle right after DONE
        run_op(8'd10, 8'd20, 8'd30, 1'b0);
        prev_done = done_cyc;
        run_op(8'd1, 8'd2, 8'd3, 1'b0);
        chk("b2b_spacing", done_cyc - prev_done, W + 2);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            full = int'(ra) + int'(rb);
            prev_done = done_cyc;
            run_op(ra, rb, W'(full % 256), full >= 256);
            chk("rand_spacing", done_cyc - prev_done, W + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
